// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
//   - FSM state encoding
//   - field offsets of the entry pushed into the instruction FIFO: {adel, pc, inst}
//   - default widths and the post-reset PC
package fetch_unit_pkg;

    localparam int          kAddrWidth  = 32;
    localparam int          kInstWidth  = 32;
    localparam logic [31:0] kResetPc    = 32'hbfc00000;

    localparam int kEntryWidth  = 1 + kAddrWidth + kInstWidth;
    localparam int kEntryAdel   = 64;
    localparam int kEntryPcHi   = 63;
    localparam int kEntryPcLo   = 32;
    localparam int kEntryInstHi = 31;
    localparam int kEntryInstLo = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end.
// Walks the PC sequentially, keeps at most one instruction-ROM request in
// flight and pushes each returned instruction, tagged with its PC, into the
// downstream instruction FIFO. A redirect (flush) retargets the PC and throws
// away any response still owed by the ROM. A misaligned PC produces a single
// address-error entry and then parks the unit until the next redirect.
//
// Ports
//   clk              clock
//   rst              synchronous reset, active low
//   flush/flush_pc   one-cycle redirect request and its target
//   fifo_full        downstream FIFO is full; no new request is issued
//   fifo_write_en    push strobe into the FIFO
//   fifo_write_data  entry {adel, pc, inst}
//   rom_req/addr     ROM request (valid/ready with rom_ready)
//   rom_rvalid/rdata ROM response, one cycle wide
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FETCH | issue a request for pc (or emit an address-error entry)
// ST_WAIT  | request accepted, waiting for its response
// ST_DROP  | request was overtaken by a flush, swallow its response
// ST_HALT  | address-error entry sent, idle until a flush
module fetch_unit #(
    parameter int                    kAddrWidth = fetch_unit_pkg::kAddrWidth,
    parameter int                    kInstWidth = fetch_unit_pkg::kInstWidth,
    parameter logic [kAddrWidth-1:0] kResetPc   = fetch_unit_pkg::kResetPc
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [kAddrWidth-1:0]            flush_pc,
    input  logic                             fifo_full,
    output logic                             fifo_write_en,
    output logic [kAddrWidth+kInstWidth:0]   fifo_write_data,
    output logic                             rom_req,
    output logic [kAddrWidth-1:0]            rom_addr,
    input  logic                             rom_ready,
    input  logic                             rom_rvalid,
    input  logic [kInstWidth-1:0]            rom_rdata
);
    import fetch_unit_pkg::*;

    fetch_state_e          state_q, state_d;
    logic [kAddrWidth-1:0] pc_q, pc_d;
    logic [kAddrWidth-1:0] inflight_pc_q, inflight_pc_d;

    logic                  req;
    logic                  write;
    logic                  adel;
    logic                  misaligned;
    logic [kAddrWidth-1:0] entry_pc;
    logic [kInstWidth-1:0] entry_inst;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        req           = 1'b0;
        write         = 1'b0;
        adel          = 1'b0;
        entry_pc      = pc_q;
        entry_inst    = '0;
        misaligned    = (pc_q[1:0] != 2'b00);

        case (state_q)
            ST_FETCH: begin
                if (misaligned) begin
                    if (!fifo_full) begin
                        write   = 1'b1;
                        adel    = 1'b1;
                        state_d = ST_HALT;
                    end
                end else begin
                    req = !fifo_full;
                    if (req && rom_ready) begin
                        inflight_pc_d = pc_q;
                        state_d       = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (rom_rvalid) begin
                    write      = 1'b1;
                    entry_pc   = inflight_pc_q;
                    entry_inst = rom_rdata;
                    pc_d       = inflight_pc_q + kAddrWidth'(4);
                    state_d    = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (rom_rvalid) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // A redirect wins over everything else this cycle. A request that was
        // handshaken in the same cycle is already owned by the ROM, so its
        // response still has to be absorbed in ST_DROP.
        if (flush) begin
            pc_d  = flush_pc;
            write = 1'b0;
            case (state_q)
                ST_FETCH: state_d = (req && rom_ready) ? ST_DROP : ST_FETCH;
                ST_WAIT:  state_d = rom_rvalid ? ST_FETCH : ST_DROP;
                ST_DROP:  state_d = rom_rvalid ? ST_FETCH : ST_DROP;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= kResetPc;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Outputs are forced quiet while reset is held, independent of the
    // registered state.
    assign rom_req         = rst && req;
    assign rom_addr        = rst ? pc_q : '0;
    assign fifo_write_en   = rst && write;
    assign fifo_write_data = (rst && write) ? {adel, entry_pc, entry_inst} : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fifo_full;
    logic        fifo_write_en;
    logic [64:0] fifo_write_data;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ready;
    logic        rom_rvalid;
    logic [31:0] rom_rdata;

    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .fifo_full       (fifo_full),
        .fifo_write_en   (fifo_write_en),
        .fifo_write_data (fifo_write_data),
        .rom_req         (rom_req),
        .rom_addr        (rom_addr),
        .rom_ready       (rom_ready),
        .rom_rvalid      (rom_rvalid),
        .rom_rdata       (rom_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        flush;
        logic [31:0] flush_pc;
        logic        full;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [64:0] e_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic r, logic f, logic [31:0] fp, logic fu,
                                logic rd, logic rv, logic [31:0] rdat,
                                logic er, logic [31:0] ea, logic ew, logic [64:0] ed);
        vec_t v;
        v.name = n; v.rst = r; v.flush = f; v.flush_pc = fp; v.full = fu;
        v.ready = rd; v.rvalid = rv; v.rdata = rdat;
        v.e_req = er; v.e_addr = ea; v.e_we = ew; v.e_data = ed;
        return v;
    endfunction

    function automatic logic [64:0] ent(logic a, logic [31:0] pc, logic [31:0] inst);
        return {a, pc, inst};
    endfunction

    function automatic logic [31:0] rom_word(logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'hc001d00d;
    endfunction

    task automatic chk(string name, logic [64:0] act, logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; drives one cycle and checks mid-cycle.
    task automatic apply(vec_t v);
        rst        = v.rst;
        flush      = v.flush;
        flush_pc   = v.flush_pc;
        fifo_full  = v.full;
        rom_ready  = v.ready;
        rom_rvalid = v.rvalid;
        rom_rdata  = v.rdata;
        @(negedge clk);
        chk({v.name, " rom_req"}, 65'(rom_req), 65'(v.e_req));
        chk({v.name, " write_en"}, 65'(fifo_write_en), 65'(v.e_we));
        if (v.e_req || !v.rst) chk({v.name, " rom_addr"}, 65'(rom_addr), 65'(v.e_addr));
        if (v.e_we || !v.rst)  chk({v.name, " write_data"}, fifo_write_data, v.e_data);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I0 = 32'h11111111, I1 = 32'h22222222, I2 = 32'h33333333;
    localparam logic [31:0] I3 = 32'h44444444, I4 = 32'h55555555, I5 = 32'h66666666;
    localparam logic [31:0] I6 = 32'h77777777, I7 = 32'h88888888, I8 = 32'h99999999;

    // reference model state for the random phase
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic        pend;
    logic        stale;
    logic        halted;
    int          cnt;
    logic        rvalid_real;
    logic        e_req;
    logic        e_we;
    logic [64:0] e_data;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; flush = 1'b0; flush_pc = '0; fifo_full = 1'b0;
        rom_ready = 1'b0; rom_rvalid = 1'b0; rom_rdata = '0;

        // reset, then three sequential fetches with response two cycles after handshake
        tbl.push_back(mk("rst0", 0,0,0,0,1,1,32'hdeadbeef, 0,0,0,0));
        tbl.push_back(mk("rst1", 0,1,32'h1234,0,1,1,32'hdeadbeef, 0,0,0,0));
        tbl.push_back(mk("seq_req0", 1,0,0,0,1,0,0, 1,32'hbfc00000,0,0));
        tbl.push_back(mk("seq_w0",   1,0,0,0,1,0,0, 0,0,0,0));
        tbl.push_back(mk("seq_wr0",  1,0,0,0,1,1,I0, 0,0,1,ent(0,32'hbfc00000,I0)));
        tbl.push_back(mk("seq_req1", 1,0,0,0,1,0,0, 1,32'hbfc00004,0,0));
        tbl.push_back(mk("seq_w1",   1,0,0,0,1,0,0, 0,0,0,0));
        tbl.push_back(mk("seq_wr1",  1,0,0,0,1,1,I1, 0,0,1,ent(0,32'hbfc00004,I1)));
        tbl.push_back(mk("seq_req2", 1,0,0,0,1,0,0, 1,32'hbfc00008,0,0));
        tbl.push_back(mk("seq_w2",   1,0,0,0,1,0,0, 0,0,0,0));
        tbl.push_back(mk("seq_wr2",  1,0,0,0,1,1,I2, 0,0,1,ent(0,32'hbfc00008,I2)));
        // fifo_full back-pressure
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk("full_hold", 1,0,0,1,1,0,0, 0,0,0,0));
        tbl.push_back(mk("full_rel",   1,0,0,0,0,0,0, 1,32'hbfc0000c,0,0));
        tbl.push_back(mk("stall_hold", 1,0,0,0,0,0,0, 1,32'hbfc0000c,0,0));
        tbl.push_back(mk("full_drop",  1,0,0,1,1,0,0, 0,0,0,0));
        tbl.push_back(mk("full_req",   1,0,0,0,1,0,0, 1,32'hbfc0000c,0,0));
        tbl.push_back(mk("full_wr",    1,0,0,0,1,1,I3, 0,0,1,ent(0,32'hbfc0000c,I3)));
        // misaligned redirect -> address-error entry, halt, resume on flush
        tbl.push_back(mk("mis_flush", 1,1,32'h80000102,0,0,0,0, 1,32'hbfc00010,0,0));
        tbl.push_back(mk("mis_entry", 1,0,0,0,1,0,0, 0,0,1,ent(1,32'h80000102,0)));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk("halt_idle", 1,0,0,0,1,(i == 4),32'hbad0bad0, 0,0,0,0));
        tbl.push_back(mk("halt_flush", 1,1,32'h80000200,0,1,0,0, 0,0,0,0));
        tbl.push_back(mk("resume_req", 1,0,0,0,1,0,0, 1,32'h80000200,0,0));
        tbl.push_back(mk("resume_wr",  1,0,0,0,1,1,I4, 0,0,1,ent(0,32'h80000200,I4)));

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i]);

        // flush while waiting; late response is swallowed
        apply(mk("h1_req",    1,0,0,0,1,0,0, 1,32'h80000204,0,0));
        apply(mk("h1_flush",  1,1,32'h80000100,0,1,0,0, 0,0,0,0));
        apply(mk("h1_drop",   1,0,0,0,1,0,0, 0,0,0,0));
        apply(mk("h1_stale",  1,0,0,0,1,1,32'hfeedface, 0,0,0,0));
        apply(mk("h1_req2",   1,0,0,0,1,0,0, 1,32'h80000100,0,0));
        apply(mk("h1_wr",     1,0,0,0,1,1,I5, 0,0,1,ent(0,32'h80000100,I5)));
        // flush coincident with the response
        apply(mk("h2_req",    1,0,0,0,1,0,0, 1,32'h80000104,0,0));
        apply(mk("h2_flush",  1,1,32'h90000000,0,1,1,32'h0badf00d, 0,0,0,0));
        apply(mk("h2_hold",   1,0,0,0,0,0,0, 1,32'h90000000,0,0));
        apply(mk("h2_req2",   1,0,0,0,1,0,0, 1,32'h90000000,0,0));
        apply(mk("h2_wr",     1,0,0,0,1,1,I6, 0,0,1,ent(0,32'h90000000,I6)));
        // flush coincident with the handshake
        apply(mk("h2b_flush", 1,1,32'ha0000000,0,1,0,0, 1,32'h90000004,0,0));
        apply(mk("h2b_drop",  1,0,0,0,1,0,0, 0,0,0,0));
        apply(mk("h2b_stale", 1,0,0,0,1,1,32'h12345678, 0,0,0,0));
        apply(mk("h2b_req",   1,0,0,0,0,0,0, 1,32'ha0000000,0,0));
        // PC wrap
        apply(mk("h3_flush",  1,1,32'hfffffffc,0,0,0,0, 1,32'ha0000000,0,0));
        apply(mk("h3_req",    1,0,0,0,1,0,0, 1,32'hfffffffc,0,0));
        apply(mk("h3_wr",     1,0,0,0,1,1,I7, 0,0,1,ent(0,32'hfffffffc,I7)));
        apply(mk("h3_wrap",   1,0,0,0,0,0,0, 1,32'h00000000,0,0));
        // reset while waiting
        apply(mk("h4_flush",  1,1,32'hfffffffc,0,0,0,0, 1,32'h00000000,0,0));
        apply(mk("h4_req",    1,0,0,0,1,0,0, 1,32'hfffffffc,0,0));
        apply(mk("h4_rst0",   0,0,0,0,1,1,I8, 0,0,0,0));
        apply(mk("h4_rst1",   0,0,0,0,1,0,0, 0,0,0,0));
        apply(mk("h4_restart",1,0,0,0,0,0,0, 1,32'hbfc00000,0,0));

        // random phase against a transaction-level model:
        // fetched stream = consecutive PCs from the last redirect target,
        // responses to requests issued before a redirect are discarded.
        exp_pc = kResetPc; pend = 1'b0; stale = 1'b0; halted = 1'b0;
        pend_addr = '0; cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst   = 1'b1;
            flush = ($urandom_range(15) == 0);
            case ($urandom_range(7))
                0:       flush_pc = 32'hfffffff0 + 32'($urandom_range(3) * 4);
                1:       flush_pc = $urandom;
                default: flush_pc = $urandom & ~32'h3;
            endcase
            fifo_full = ($urandom_range(3) == 0);
            rom_ready = ($urandom_range(2) != 0);
            rvalid_real = 1'b0;
            if (pend) begin
                cnt--;
                rvalid_real = (cnt == 0);
            end
            if (rvalid_real) begin
                rom_rvalid = 1'b1;
                rom_rdata  = rom_word(pend_addr);
            end else begin
                rom_rvalid = !pend && ($urandom_range(19) == 0);
                rom_rdata  = $urandom;
            end
            @(negedge clk);
            e_we = 1'b0;
            e_data = '0;
            if (!flush) begin
                if (rvalid_real && !stale) begin
                    e_we = 1'b1;
                    e_data = ent(0, pend_addr, rom_rdata);
                end else if (!halted && !pend && exp_pc[1:0] != 2'b00 && !fifo_full) begin
                    e_we = 1'b1;
                    e_data = ent(1, exp_pc, 0);
                end
            end
            e_req = !halted && !pend && exp_pc[1:0] == 2'b00 && !fifo_full;
            chk("rnd write_en", 65'(fifo_write_en), 65'(e_we));
            if (e_we) chk("rnd write_data", fifo_write_data, e_data);
            chk("rnd rom_req", 65'(rom_req), 65'(e_req));
            if (e_req) chk("rnd rom_addr", 65'(rom_addr), 65'(exp_pc));

            if (rvalid_real) pend = 1'b0;
            if (e_we) begin
                if (e_data[kEntryAdel]) halted = 1'b1;
                else                    exp_pc = pend_addr + 32'd4;
            end
            if (e_req && rom_ready) begin
                pend = 1'b1;
                stale = 1'b0;
                pend_addr = exp_pc;
                cnt = $urandom_range(3, 1);
            end
            if (flush) begin
                exp_pc = flush_pc;
                halted = 1'b0;
                if (pend) stale = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
